// File: rtl/tag_lookup_ctrl_if.sv
// Request/response/fill/flush handshake bundle between a
// lookup client and the tag lookup controller.
interface tag_lookup_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 14
);
    localparam int TWIDTH = DWIDTH - 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [TWIDTH+AWIDTH-1:0] req_addr;
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_hit;
    logic                     fill_valid;
    logic                     fill_ready;
    logic                     flush_req;
    logic                     flush_busy;

    modport master (
        output req_valid, req_addr, resp_ready,
        output fill_valid, flush_req,
        input  req_ready, resp_valid, resp_hit,
        input  fill_ready, flush_busy
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        input  fill_valid, flush_req,
        output req_ready, resp_valid, resp_hit,
        output fill_ready, flush_busy
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Lookup/refill/flush controller sitting in front of a
// synchronous-read tag RAM (entry = {valid, tag}).
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    tag_lookup_ctrl_if.slave  bus,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int TWIDTH = DWIDTH - 1;
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        RESP,
        MISS_WAIT,
        FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [TWIDTH-1:0] tag_q, tag_d;
    logic              hit_q, hit_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    logic req_ready;
    logic resp_valid;
    logic fill_ready;
    logic flush_busy;
    logic cmp_hit;

    assign cmp_hit = ram_dout[DWIDTH-1]
                   & (ram_dout[DWIDTH-2:0] == tag_q);

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_hit   = hit_q;
    assign bus.fill_ready = fill_ready;
    assign bus.flush_busy = flush_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        hit_d      = hit_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        fill_ready = 1'b0;
        flush_busy = 1'b0;
        ram_addr   = idx_q;
        ram_din    = '0;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: begin
                // RAM address follows the request so dout is ready in CMP
                req_ready = !bus.flush_req;
                ram_addr  = bus.req_addr[AWIDTH-1:0];
                if (bus.flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (bus.req_valid) begin
                    idx_d   = bus.req_addr[AWIDTH-1:0];
                    tag_d   = bus.req_addr[AWIDTH+:TWIDTH];
                    state_d = CMP;
                end
            end
            CMP: begin
                hit_d   = cmp_hit;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = hit_q ? IDLE : MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                fill_ready = 1'b1;
                ram_din    = {1'b1, tag_q};
                ram_we     = bus.fill_valid;
                if (bus.fill_valid) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                flush_busy = 1'b1;
                ram_addr   = cnt_q;
                ram_we     = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: behavioural tag RAM, a valid/tag
// array reference model, vector table and random lookups.
module tb_tag_lookup_ctrl;
    localparam int AW = 3;
    localparam int DW = 14;
    localparam int TW = DW - 1;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    tag_lookup_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Tag RAM: no reset, registered read of the addressed entry.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    bit          mv [DEPTH];
    logic [TW-1:0] mt [DEPTH];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        int          hold;
        bit          hit;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return mv[a[AW-1:0]] && (mt[a[AW-1:0]] == a[15:AW]);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [15:0] a, input int hold,
                          input int fwait, input bit exp);
        logic [AW-1:0] idx;
        logic [TW-1:0] tg;
        idx = a[AW-1:0];
        tg  = a[15:AW];
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        #1;
        chk("accept_ready", bus.req_ready, 1'b1);
        chk("idle_addr", ram_addr, idx);
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        chk("cmp_no_resp", bus.resp_valid, 1'b0);
        chk("cmp_addr", ram_addr, idx);
        step();
        chk("resp_valid", bus.resp_valid, 1'b1);
        chk("resp_hit", bus.resp_hit, exp);
        for (int i = 0; i < hold; i++) begin
            bus.fill_valid = 1'($urandom);
            bus.flush_req  = 1'($urandom);
            bus.req_valid  = 1'($urandom);
            step();
            chk("hold_valid", bus.resp_valid, 1'b1);
            chk("hold_hit", bus.resp_hit, exp);
            chk("hold_ready", bus.req_ready, 1'b0);
            chk("hold_we", ram_we, 1'b0);
        end
        bus.fill_valid = 1'b0;
        bus.flush_req  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("post_resp_valid", bus.resp_valid, 1'b0);
        if (exp) begin
            chk("hit_idle", bus.req_ready, 1'b1);
            chk("hit_no_fill", bus.fill_ready, 1'b0);
        end else begin
            chk("miss_fill_ready", bus.fill_ready, 1'b1);
            for (int i = 0; i < fwait; i++) begin
                bus.resp_ready = 1'($urandom);
                step();
                chk("wait_fill_ready", bus.fill_ready, 1'b1);
                chk("wait_we", ram_we, 1'b0);
            end
            bus.resp_ready = 1'b0;
            bus.fill_valid = 1'b1;
            #1;
            chk("fill_we", ram_we, 1'b1);
            chk("fill_addr", ram_addr, idx);
            chk("fill_din", ram_din, {1'b1, tg});
            step();
            bus.fill_valid = 1'b0;
            chk("fill_done", bus.fill_ready, 1'b0);
            chk("fill_idle", bus.req_ready, 1'b1);
            mv[idx] = 1'b1;
            mt[idx] = tg;
        end
    endtask

    task automatic do_flush();
        bus.flush_req = 1'b1;
        #1;
        chk("flush_req_blocks", bus.req_ready, 1'b0);
        step();
        bus.flush_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("flush_busy", bus.flush_busy, 1'b1);
            chk("flush_we", ram_we, 1'b1);
            chk("flush_addr", ram_addr, i);
            chk("flush_din", ram_din, 0);
            step();
        end
        chk("flush_end", bus.flush_busy, 1'b0);
        chk("flush_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1235, 0, 1'b0};
        vecs[1] = '{16'h1235, 0, 1'b1};
        vecs[2] = '{16'h1245, 5, 1'b0};
        vecs[3] = '{16'h1245, 1, 1'b1};
        vecs[4] = '{16'h1235, 2, 1'b0};
        vecs[5] = '{16'h0000, 0, 1'b0};
        vecs[6] = '{16'h0000, 3, 1'b1};
        vecs[7] = '{16'h1235, 0, 1'b1};

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            mv[i]  = 1'b0;
            mt[i]  = '0;
        end
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        bus.fill_valid = 1'b0;
        bus.flush_req  = 1'b0;
        reset_n = 1'b0;
        #12;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_fill_ready", bus.fill_ready, 1'b0);
        chk("rst_flush_busy", bus.flush_busy, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_din", ram_din, 0);
        bus.flush_req = 1'b1;
        #1;
        chk("rst_req_ready_flush", bus.req_ready, 1'b0);
        bus.flush_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        do_flush();

        for (int i = 0; i < 8; i++) begin
            lookup(vecs[i].addr, vecs[i].hold, 1, vecs[i].hit);
        end

        // flush wins over a simultaneous request
        bus.flush_req = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h1235;
        #1;
        chk("both_req_ready", bus.req_ready, 1'b0);
        step();
        bus.flush_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("both_busy", bus.flush_busy, 1'b1);
            chk("both_blocked", bus.req_ready, 1'b0);
            chk("both_addr", ram_addr, i);
            step();
        end
        chk("both_no_resp", bus.resp_valid, 1'b0);
        chk("both_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        lookup(16'h1235, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            a = {TW'($urandom_range(0, 3)), AW'($urandom_range(0, 7))};
            lookup(a, $urandom_range(0, 2), $urandom_range(0, 2),
                   model_hit(a));
        end

        // reset in the middle of a flush
        for (int i = 4; i < DEPTH; i++) begin
            logic [15:0] a;
            a = {TW'(13'h100 + i), AW'(i)};
            lookup(a, 0, 0, model_hit(a));
        end
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        repeat (3) step();
        chk("mid_addr", ram_addr, 3);
        chk("mid_we", ram_we, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 1'b0);
        chk("mid_rst_busy", bus.flush_busy, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b1);
        chk("mid_rst_din", ram_din, 0);
        chk("mid_rst_resp", bus.resp_valid, 1'b0);
        chk("mid_rst_fill", bus.fill_ready, 1'b0);
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        for (int i = 4; i < DEPTH; i++) begin
            lookup({TW'(13'h100 + i), AW'(i)}, 0, 0, 1'b1);
        end
        lookup(16'h0000, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
